bus_arbiter: RTL and testbench

Arbitrates and sequences the shared 16-bit memory-mapped bus between several requesters, such as the instruction fetch path and the execution engine. One winner is granted per transaction by round-robin. The block drives the central address decoder and gates that decoder's result into one-hot device enables. It returns a registered read-data/ack/err response and enforces a bounded device wait time.

---
 rtl/bus_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the memory-mapped bus arbiter and its decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_t;

  // Decoder device ids; each maps to one bit of dev_en.
  localparam logic [2:0] DID_RAM  = 3'd0;
  localparam logic [2:0] DID_ROM  = 3'd1;
  localparam logic [2:0] DID_MAT  = 3'd2;
  localparam logic [2:0] DID_INT  = 3'd3;
  localparam logic [2:0] DID_REG  = 3'd4;
  localparam logic [2:0] DID_EXEC = 3'd5;
  localparam logic [2:0] DID_SPI  = 3'd6;

  localparam int NDEV_DEFAULT = 7;
  localparam int BUS_W        = 16;

  // Index width for a vector of n requesters; never zero.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after 'last', wrapping around.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] cand;
  logic            found;

  // Walk NREQ candidates starting just after 'last'; 'last' itself is checked last.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = last;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == IDXW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared 16-bit bus: sequences one access per grant, gates the
// external decoder into device enables, and returns a registered, time-bounded response.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15,
  parameter int NDEV    = NDEV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ*BUS_W-1:0] req_addr,
  input  logic [NREQ*BUS_W-1:0] req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  rsp_err,
  output logic [BUS_W-1:0]      rsp_rdata,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [BUS_W-1:0]      bus_addr,
  output logic [BUS_W-1:0]      bus_wdata,
  input  logic                  dec_hit,
  input  logic [2:0]            dec_did,
  output logic [NDEV-1:0]       dev_en,
  input  logic                  dev_rdy,
  input  logic [BUS_W-1:0]      dev_rdata,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester raises req with its addr/wdata/wr and holds them until sampled in
  // IDLE; gnt then stays high through ACCESS and RESP, and ack pulses for exactly the RESP
  // cycle with rsp_err/rsp_rdata. Dropping req after the grant does not cancel the access.

  localparam int IDXW = idx_w(NREQ);
  localparam int CW   = $clog2(TIMEOUT + 1);

  bus_state_t      state;
  logic [IDXW-1:0] last;
  logic [IDXW-1:0] widx;
  logic [CW-1:0]   wait_cnt;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDXW-1:0]  arb_idx;
  logic [BUS_W-1:0] sel_addr;
  logic [BUS_W-1:0] sel_wdata;
  logic             sel_wr;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req  (req),
    .last (last),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = req_addr[i*BUS_W +: BUS_W];
        sel_wdata = req_wdata[i*BUS_W +: BUS_W];
      end
    end
  end

  assign sel_wr    = req_wr[arb_idx];
  assign dbg_state = state;

  // Enables follow the decoder directly so a device sees its select in the same ACCESS cycle.
  always_comb begin
    dev_en = '0;
    if (state == ACCESS && dec_hit) begin
      for (int d = 0; d < NDEV; d++) begin
        if (dec_did == 3'(d)) dev_en[d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDXW'(NREQ - 1);
      widx      <= '0;
      wait_cnt  <= '0;
      gnt       <= '0;
      ack       <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack       <= '0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          if (|req) begin
            widx      <= arb_idx;
            gnt       <= arb_gnt;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_wdata;
            bus_rd    <= !sel_wr;
            bus_wr    <= sel_wr;
            wait_cnt  <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Decoder miss wins over dev_rdy; dev_rdy wins over a counter that just expired.
          if (!dec_hit) begin
            ack       <= gnt;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            state     <= RESP;
          end else if (dev_rdy) begin
            ack       <= gnt;
            rsp_err   <= 1'b0;
            rsp_rdata <= bus_rd ? dev_rdata : '0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            ack       <= gnt;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          ack       <= '0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          gnt       <= '0;
          last      <= widx;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a transaction-level latency model predicts every cycle's outputs.
module tb_bus_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 15;
  localparam int NDEV    = 7;
  localparam int W       = NREQ + 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req, req_wr, gnt, ack;
  logic [NREQ*16-1:0] req_addr, req_wdata;
  logic               rsp_err, bus_rd, bus_wr, dec_hit, dev_rdy;
  logic [15:0]        rsp_rdata, bus_addr, bus_wdata, dev_rdata;
  logic [2:0]         dec_did;
  logic [NDEV-1:0]    dev_en;
  logic [1:0]         dbg_state;

  bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .NDEV(NDEV)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .dec_hit(dec_hit), .dec_did(dec_did), .dev_en(dev_en), .dev_rdy(dev_rdy),
    .dev_rdata(dev_rdata), .dbg_state(dbg_state)
  );

  // Address decoder: top nibble 0..6 selects that device, anything above misses.
  assign dec_hit = (bus_rd || bus_wr) && (bus_addr[15:12] < 4'd7);
  assign dec_did = bus_addr[14:12];

  // ---------------- model state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        has[NREQ], granted_f[NREQ], t_wr[NREQ];
  logic [15:0] t_addr[NREQ], t_wdata[NREQ], t_rdata[NREQ];
  int          t_wait[NREQ], t_start[NREQ], refill[NREQ];

  logic        busy, c_wr, c_hit;
  logic [2:0]  c_did;
  logic [15:0] c_addr, c_wdata, c_rdata;
  int          tg, lat, w, cur_wait, last_m;
  logic        gen_en, drop_en;

  int              obs_lat, den_cnt;
  logic            obs_err;
  logic [15:0]     obs_rdata;
  logic [NDEV-1:0] den_seen;
  logic [NREQ-1:0] obs_gnt;
  int              gseq[$];
  logic [W-1:0]    exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_rsp"}, 32'({rsp_err, rsp_rdata}), 32'd0);
    chk({tag, "_rdwr"}, 32'({bus_rd, bus_wr}), 32'd0);
    chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus_wdata), 32'd0);
    chk({tag, "_dev_en"}, 32'(dev_en), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_txn(input int i);
    has[i]       = 1'b1;
    granted_f[i] = 1'b0;
    t_start[i]   = cyc;
    t_wr[i]      = 1'($urandom_range(0, 1));
    t_addr[i]    = {4'($urandom_range(0, 9)), 12'($urandom)};
    t_wdata[i]   = 16'($urandom);
    t_rdata[i]   = 16'($urandom);
    t_wait[i]    = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(13, 18));
  endtask

  task automatic load(input int i, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      input int wt, input logic [15:0] rd);
    has[i]       = 1'b1;
    granted_f[i] = 1'b0;
    t_start[i]   = cyc + 1;
    t_wr[i]      = wr;
    t_addr[i]    = a;
    t_wdata[i]   = wd;
    t_wait[i]    = wt;
    t_rdata[i]   = rd;
  endtask

  // One negedge: compare DUT against the model, retire, drive, then arbitrate.
  task automatic do_cycle();
    int              rr, nw;
    logic            in_acc, in_rsp, idle_now, err, found;
    logic [NREQ-1:0] eg, ea;
    logic [NDEV-1:0] ed;
    logic [W-1:0]    e;
    logic [15:0]     erd;
    rr       = busy ? cyc - tg : 0;
    in_acc   = busy && rr >= 1 && rr <= lat - 1;
    in_rsp   = busy && rr == lat;
    idle_now = !busy || rr > lat;
    eg = (in_acc || in_rsp) ? NREQ'(1 << w) : '0;
    ea = in_rsp ? NREQ'(1 << w) : '0;
    ed = (in_acc && c_hit) ? NDEV'(1 << c_did) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("ack", 32'(ack), 32'(ea));
    chk("bus_rd", 32'(bus_rd), 32'(in_acc && !c_wr));
    chk("bus_wr", 32'(bus_wr), 32'(in_acc && c_wr));
    chk("dev_en", 32'(dev_en), 32'(ed));
    if (in_acc) begin
      chk("bus_addr", 32'(bus_addr), 32'(c_addr));
      chk("bus_wdata", 32'(bus_wdata), 32'(c_wdata));
      den_seen = den_seen | dev_en;
      if (dev_en != '0) den_cnt++;
      if (rr == 1) obs_gnt = gnt;
    end
    if (ack != '0) begin
      if (exp_q.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp", 32'({ack, rsp_err, rsp_rdata}), 32'(e));
      end
      obs_err   = rsp_err;
      obs_rdata = rsp_rdata;
      obs_lat   = cyc - t_start[w];
    end
    if (in_rsp) begin
      last_m       = w;
      has[w]       = 1'b0;
      granted_f[w] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!has[i]) begin
        if (refill[i] > 0) begin
          refill[i]--;
          new_txn(i);
          t_addr[i] = {4'($urandom_range(0, 6)), 12'($urandom)};
          t_wait[i] = int'($urandom_range(0, 2));
        end else if (gen_en && $urandom_range(0, 2) == 0) begin
          new_txn(i);
        end
      end
      req[i]               = has[i] && (!granted_f[i] || !drop_en || $urandom_range(0, 3) != 0);
      req_wr[i]            = t_wr[i];
      req_addr[i*16 +: 16]  = t_addr[i];
      req_wdata[i*16 +: 16] = t_wdata[i];
    end
    if (in_acc && c_hit) begin
      dev_rdy   = (rr == cur_wait + 1);
      dev_rdata = dev_rdy ? c_rdata : 16'($urandom);
    end else begin
      dev_rdy   = 1'($urandom_range(0, 1));
      dev_rdata = 16'($urandom);
    end
    if (idle_now && (|req)) begin
      nw    = last_m;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found) begin
          nw = (nw + 1) % NREQ;
          if (req[nw]) found = 1'b1;
        end
      end
      w        = nw;
      c_wr     = t_wr[w];
      c_addr   = t_addr[w];
      c_wdata  = t_wdata[w];
      c_rdata  = t_rdata[w];
      cur_wait = t_wait[w];
      c_hit    = c_addr[15:12] < 4'd7;
      c_did    = c_addr[14:12];
      if (!c_hit) begin
        lat = 2; err = 1'b1;
      end else if (cur_wait <= TIMEOUT) begin
        lat = 2 + cur_wait; err = 1'b0;
      end else begin
        lat = TIMEOUT + 2; err = 1'b1;
      end
      erd = (!err && !c_wr) ? c_rdata : 16'h0;
      exp_q.push_back({NREQ'(1 << w), err, erd});
      granted_f[w] = 1'b1;
      busy         = 1'b1;
      tg           = cyc;
      den_seen     = '0;
      den_cnt      = 0;
      gseq.push_back(w);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    do_cycle();
  endtask

  function automatic logic quiet();
    logic q;
    q = !busy || (cyc - tg > lat);
    for (int i = 0; i < NREQ; i++) q = q && !has[i] && refill[i] == 0;
    return q;
  endfunction

  task automatic run_until_idle(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!quiet() && n < 300);
    if (!quiet()) chk({tag, "_idle_bound"}, 32'd1, 32'd0);
  endtask

  task automatic model_reset();
    busy   = 1'b0;
    last_m = NREQ - 1;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      has[i]       = 1'b0;
      granted_f[i] = 1'b0;
      refill[i]    = 0;
    end
    req = '0;
  endtask

  // ---------------- stimulus and report ----------------
  initial begin
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    dev_rdy = 1'b0; dev_rdata = '0;
    gen_en = 1'b0; drop_en = 1'b0;
    tg = 0; lat = 0; w = 0; cur_wait = 0;
    c_wr = 1'b0; c_hit = 1'b0; c_did = '0; c_addr = '0; c_wdata = '0; c_rdata = '0;
    obs_lat = 0; den_cnt = 0; obs_err = 1'b0; obs_rdata = '0; den_seen = '0; obs_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      t_wr[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0; t_rdata[i] = '0;
      t_wait[i] = 0; t_start[i] = 0;
    end
    model_reset();

    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters held continuously: grants must alternate starting at 0.
    gseq.delete();
    refill[0] = 2;
    refill[1] = 2;
    run_until_idle("alternate");
    chk("alt_count", 32'(gseq.size()), 32'd4);
    if (gseq.size() == 4) begin
      chk("alt_g0", 32'(gseq[0]), 32'd0);
      chk("alt_g1", 32'(gseq[1]), 32'd1);
      chk("alt_g2", 32'(gseq[2]), 32'd0);
      chk("alt_g3", 32'(gseq[3]), 32'd1);
    end

    load(0, 1'b0, 16'h1004, 16'h0000, 0, 16'hBEEF);
    run_until_idle("zero_wait_read");
    chk("zw_latency", 32'(obs_lat), 32'd2);
    chk("zw_dev_en", 32'(den_seen), 32'(7'b0000010));
    chk("zw_dev_en_cycles", 32'(den_cnt), 32'd1);
    chk("zw_rdata", 32'(obs_rdata), 32'hBEEF);
    chk("zw_err", 32'(obs_err), 32'd0);

    load(0, 1'b1, 16'h7000, 16'h1111, 0, 16'h2222);
    run_until_idle("miss_write");
    chk("miss_latency", 32'(obs_lat), 32'd2);
    chk("miss_dev_en", 32'(den_seen), 32'd0);
    chk("miss_err", 32'(obs_err), 32'd1);
    chk("miss_rdata", 32'(obs_rdata), 32'd0);

    load(1, 1'b1, 16'h6002, 16'h5A5A, 3, 16'h3333);
    run_until_idle("wait3_write");
    chk("w3_latency", 32'(obs_lat), 32'd5);
    chk("w3_dev_en", 32'(den_seen), 32'(7'b1000000));
    chk("w3_dev_en_cycles", 32'(den_cnt), 32'd4);
    chk("w3_err", 32'(obs_err), 32'd0);
    chk("w3_rdata", 32'(obs_rdata), 32'd0);

    load(0, 1'b0, 16'h3000, 16'h0000, 1000, 16'h4444);
    run_until_idle("timeout_read");
    chk("to_latency", 32'(obs_lat), 32'd17);
    chk("to_err", 32'(obs_err), 32'd1);
    chk("to_rdata", 32'(obs_rdata), 32'd0);

    load(0, 1'b0, 16'h2000, 16'h0000, 1, 16'h1234);
    run_until_idle("after_timeout");
    chk("at_latency", 32'(obs_lat), 32'd3);
    chk("at_err", 32'(obs_err), 32'd0);
    chk("at_rdata", 32'(obs_rdata), 32'h1234);

    // Reset while a long read sits in ACCESS.
    load(0, 1'b0, 16'h1000, 16'h0000, 50, 16'h5555);
    repeat (3) tick();
    @(negedge clk);
    cyc++;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("reset_mid");
    model_reset();
    repeat (2) begin
      @(negedge clk);
      cyc++;
      chk("ack_in_reset", 32'(ack), 32'd0);
    end
    rst_n = 1'b1;
    load(1, 1'b0, 16'h4010, 16'h0000, 0, 16'hCAFE);
    run_until_idle("post_reset");
    chk("pr_gnt", 32'(obs_gnt), 32'(2'b10));
    chk("pr_latency", 32'(obs_lat), 32'd2);
    chk("pr_rdata", 32'(obs_rdata), 32'hCAFE);

    // Randomized traffic with requests sometimes dropped after the grant.
    gen_en  = 1'b1;
    drop_en = 1'b1;
    repeat (1500) tick();
    gen_en = 1'b0;
    run_until_idle("random");
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
